mdu: RTL and testbench
======================

Name: mdu

Overview:
- Multiply/divide unit in the E stage of the pipelined MIPS core; owns the HI/LO registers.
- Executes mult/multu/div/divu with fixed multi-cycle latency and single-cycle mthi/mtlo.
- mfhi/mflo read its HI/LO outputs; that value travels down the pipeline and lands in the register file through the writeback WD path.
- The hazard unit stalls D on (start | busy) when a HI/LO-touching instruction is in D.

Parameters:
MULT_CYCLES, 5, cycles from accepted mult/multu to HI/LO commit (>=1)
DIV_CYCLES, 10, cycles from accepted div/divu to HI/LO commit (>=1)

Ports:
clk  in  1  clock, rising edge
reset  in  1  asynchronous, active-low (0 = reset); one clock
start  in  1  E-stage instruction is an MDU op; qualifies op/A/B
op  in  3  0 MULT, 1 MULTU, 2 DIV, 3 DIVU, 4 MTHI, 5 MTLO, 6 MADD, 7 MADDU
A  in  32  rs operand (forwarded)
B  in  32  rt operand (forwarded)
busy  out  1  mult/div in flight
HI  out  32  HI register
LO  out  32  LO register

Behaviour:
- Reset (reset==0, async): HI=0, LO=0, busy=0, counter=0, state IDLE, pending results cleared. Asserting reset mid-operation abandons the op; no commit after release.
- States: IDLE, BUSY.
- IDLE, start=1, op in {MULT,MULTU,DIV,DIVU} (plus MADD/MADDU if enabled): on the edge, latch the result into pending_hi/pending_lo, load counter with MULT_CYCLES or DIV_CYCLES, busy=1, go to BUSY. busy therefore rises the cycle after start.
- BUSY: counter decrements each edge. On the edge where counter==1, HI/LO <= pending, busy=0, go to IDLE. Total: HI/LO visible exactly N cycles after the start edge (N = op latency).
- MTHI/MTLO in IDLE: HI (or LO) <= A on the same edge; busy stays 0; other register unchanged.
- start while BUSY (any op): ignored entirely. The hazard unit guarantees this does not happen; the bench checks the ignore.
- Arithmetic:
  - MULT: {HI,LO} = signed A*B, 64-bit.
  - MULTU: {HI,LO} = unsigned A*B, 64-bit.
  - DIV: LO = quotient truncated toward zero; HI = remainder with the sign of the dividend.
  - DIVU: LO = unsigned quotient; HI = unsigned remainder.
  - DIV with A=0x80000000, B=0xFFFFFFFF: LO=0x80000000, HI=0.
- Divide by zero (B==0, DIV/DIVU): the op is accepted and busy runs the full DIV_CYCLES; at commit HI/LO keep their previous values.
- HI/LO outputs are plain register outputs with no bypass of pending values; reading them while busy is prevented upstream.
- Opcodes 6/7 without the optional feature: treated as no-op; no busy, no HI/LO change.

Optional Feature:
- Macro: MDU_MADD_EN.
- Defined: op 6 MADD gives {HI,LO} += signed A*B; op 7 MADDU gives {HI,LO} += unsigned A*B. Arithmetic is modulo 2^64. The {HI,LO} addend is sampled at the start edge. Latency is MULT_CYCLES, with busy behaviour the same as MULT.
- Not defined: ops 6/7 are no-ops as above. No accumulate logic is synthesised.

Test Plan:
- Reset behaviour: drive reset=0 mid-DIV (counter=4) -> HI=LO=0 and busy=0 immediately; after release, no commit ever occurs.
- MULT latency (defaults): MULT A=0xFFFFFFFE(-2), B=3 -> busy=1 for 5 cycles, then HI=0xFFFFFFFF, LO=0xFFFFFFFA. MULTU with the same operands -> HI=0x00000002, LO=0xFFFFFFFA.
- DIV signs: DIV A=-7, B=2 -> LO=0xFFFFFFFD, HI=0xFFFFFFFF after 10 cycles. DIVU A=7, B=2 -> LO=3, HI=1. Overflow case A=0x80000000, B=-1 -> LO=0x80000000, HI=0.
- Divide by zero: preload HI=0x11, LO=0x22 via MTHI/MTLO, then DIV A=5, B=0 -> busy for 10 cycles, then HI=0x11, LO=0x22.
- Start while busy: MULT 3*4, then MTLO A=0xDEAD and DIVU during busy -> both ignored; commit LO=12, HI=0 at cycle 5.
- MDU_MADD_EN: with HI=0, LO=0xFFFFFFFF, MADDU A=1, B=1 -> HI=1, LO=0 after 5 cycles. Without the macro, the same stimulus -> no busy, HI/LO unchanged.

Source files
------------

// File: rtl/mdu.sv
// Multiply/divide unit for the E stage; owns HI/LO and commits results after a fixed latency.
// Optional MADD/MADDU accumulate ops are built only when MDU_MADD_EN is defined.
module mdu #(
  parameter int MULT_CYCLES = 5,
  parameter int DIV_CYCLES  = 10
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        start,
  input  logic [2:0]  op,
  input  logic [31:0] A,
  input  logic [31:0] B,
  output logic        busy,
  output logic [31:0] HI,
  output logic [31:0] LO
);

  localparam int MAX_CYC = (MULT_CYCLES > DIV_CYCLES) ? MULT_CYCLES : DIV_CYCLES;
  localparam int CNT_W   = $clog2(MAX_CYC + 1);

  localparam logic [2:0] OP_MULT  = 3'd0;
  localparam logic [2:0] OP_MULTU = 3'd1;
  localparam logic [2:0] OP_DIV   = 3'd2;
  localparam logic [2:0] OP_DIVU  = 3'd3;
  localparam logic [2:0] OP_MTHI  = 3'd4;
  localparam logic [2:0] OP_MTLO  = 3'd5;
`ifdef MDU_MADD_EN
  localparam logic [2:0] OP_MADD  = 3'd6;
  localparam logic [2:0] OP_MADDU = 3'd7;
`endif

  typedef enum logic {S_IDLE, S_BUSY} state_t;

  // Signed divide returning {remainder, quotient}; the one overflowing case is pinned explicitly.
  function automatic logic [63:0] sdiv(input logic signed [31:0] a, input logic signed [31:0] b);
    logic signed [31:0] q;
    logic signed [31:0] r;
    if (b == 32'sd0) begin
      q = 32'sd0;
      r = 32'sd0;
    end else if (a == 32'sh8000_0000 && b == -32'sd1) begin
      q = a;
      r = 32'sd0;
    end else begin
      q = a / b;
      r = a % b;
    end
    return {r, q};
  endfunction

  function automatic logic [63:0] udiv(input logic [31:0] a, input logic [31:0] b);
    logic [31:0] q;
    logic [31:0] r;
    if (b == 32'd0) begin
      q = 32'd0;
      r = 32'd0;
    end else begin
      q = a / b;
      r = a % b;
    end
    return {r, q};
  endfunction

  state_t             state_q, state_d;
  logic [CNT_W-1:0]   cnt_q, cnt_d;
  logic [31:0]        hi_q, hi_d, lo_q, lo_d;
  logic [31:0]        pend_hi_q, pend_hi_d, pend_lo_q, pend_lo_d;
  logic               pend_wr_q, pend_wr_d;

  logic signed [63:0] a_sx, b_sx, prod_s;
  logic        [63:0] prod_u;
  logic        [63:0] div_s, div_u;

  assign a_sx   = {{32{A[31]}}, A};
  assign b_sx   = {{32{B[31]}}, B};
  assign prod_s = a_sx * b_sx;
  assign prod_u = {32'd0, A} * {32'd0, B};
  assign div_s  = sdiv(A, B);
  assign div_u  = udiv(A, B);

  always_comb begin
    state_d   = state_q;
    cnt_d     = cnt_q;
    hi_d      = hi_q;
    lo_d      = lo_q;
    pend_hi_d = pend_hi_q;
    pend_lo_d = pend_lo_q;
    pend_wr_d = pend_wr_q;
    unique case (state_q)
      S_IDLE: begin
        if (start) begin
          case (op)
            OP_MULT: begin
              {pend_hi_d, pend_lo_d} = prod_s;
              pend_wr_d = 1'b1;
              cnt_d     = CNT_W'(MULT_CYCLES);
              state_d   = S_BUSY;
            end
            OP_MULTU: begin
              {pend_hi_d, pend_lo_d} = prod_u;
              pend_wr_d = 1'b1;
              cnt_d     = CNT_W'(MULT_CYCLES);
              state_d   = S_BUSY;
            end
            OP_DIV: begin
              {pend_hi_d, pend_lo_d} = div_s;
              pend_wr_d = (B != 32'd0);
              cnt_d     = CNT_W'(DIV_CYCLES);
              state_d   = S_BUSY;
            end
            OP_DIVU: begin
              {pend_hi_d, pend_lo_d} = div_u;
              pend_wr_d = (B != 32'd0);
              cnt_d     = CNT_W'(DIV_CYCLES);
              state_d   = S_BUSY;
            end
            OP_MTHI: hi_d = A;
            OP_MTLO: lo_d = A;
`ifdef MDU_MADD_EN
            // Accumulator addend is the HI/LO value at the start edge.
            OP_MADD: begin
              {pend_hi_d, pend_lo_d} = {hi_q, lo_q} + prod_s;
              pend_wr_d = 1'b1;
              cnt_d     = CNT_W'(MULT_CYCLES);
              state_d   = S_BUSY;
            end
            OP_MADDU: begin
              {pend_hi_d, pend_lo_d} = {hi_q, lo_q} + prod_u;
              pend_wr_d = 1'b1;
              cnt_d     = CNT_W'(MULT_CYCLES);
              state_d   = S_BUSY;
            end
`endif
            default: ;
          endcase
        end
      end
      S_BUSY: begin
        cnt_d = cnt_q - CNT_W'(1);
        if (cnt_q == CNT_W'(1)) begin
          if (pend_wr_q) begin
            hi_d = pend_hi_q;
            lo_d = pend_lo_q;
          end
          state_d = S_IDLE;
        end
      end
      default: state_d = S_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q   <= S_IDLE;
      cnt_q     <= '0;
      hi_q      <= '0;
      lo_q      <= '0;
      pend_hi_q <= '0;
      pend_lo_q <= '0;
      pend_wr_q <= 1'b0;
    end else begin
      state_q   <= state_d;
      cnt_q     <= cnt_d;
      hi_q      <= hi_d;
      lo_q      <= lo_d;
      pend_hi_q <= pend_hi_d;
      pend_lo_q <= pend_lo_d;
      pend_wr_q <= pend_wr_d;
    end
  end

  assign busy = (state_q == S_BUSY);
  assign HI   = hi_q;
  assign LO   = lo_q;

endmodule

// File: tb/tb_mdu.sv
// Directed bench for mdu: latency, signed/unsigned arithmetic, divide by zero, ignored starts, reset.
module tb_mdu;

  logic        clk;
  logic        reset;
  logic        start;
  logic [2:0]  op;
  logic [31:0] A;
  logic [31:0] B;
  logic        busy;
  logic [31:0] HI;
  logic [31:0] LO;

  int checks   = 0;
  int failures = 0;
  int n;

  mdu #(.MULT_CYCLES(5), .DIV_CYCLES(10)) dut (
    .clk  (clk),
    .reset(reset),
    .start(start),
    .op   (op),
    .A    (A),
    .B    (B),
    .busy (busy),
    .HI   (HI),
    .LO   (LO)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      failures++;
      $display("FAIL %s: got 0x%08h expected 0x%08h", tag, got, exp);
    end
  endtask

  // Presents one op for a single edge; returns at the negedge after the start edge.
  task automatic issue(input logic [2:0] o, input logic [31:0] a, input logic [31:0] b);
    @(negedge clk);
    start = 1'b1;
    op    = o;
    A     = a;
    B     = b;
    @(negedge clk);
    start = 1'b0;
  endtask

  // Counts negedges on which busy is seen high, bounded.
  task automatic wait_idle(output int cyc);
    cyc = 0;
    while (busy && cyc < 100) begin
      cyc++;
      @(negedge clk);
    end
  endtask

  initial begin
    reset = 1'b0;
    start = 1'b0;
    op    = 3'd0;
    A     = 32'd0;
    B     = 32'd0;
    #12;
    check("rst_hi", HI, 32'h0);
    check("rst_lo", LO, 32'h0);
    check("rst_busy", {31'd0, busy}, 32'h0);
    @(negedge clk);
    reset = 1'b1;

    issue(3'd0, 32'hFFFF_FFFE, 32'd3);
    wait_idle(n);
    check("mult_lat", n, 32'd5);
    check("mult_hi", HI, 32'hFFFF_FFFF);
    check("mult_lo", LO, 32'hFFFF_FFFA);

    issue(3'd1, 32'hFFFF_FFFE, 32'd3);
    wait_idle(n);
    check("multu_lat", n, 32'd5);
    check("multu_hi", HI, 32'h0000_0002);
    check("multu_lo", LO, 32'hFFFF_FFFA);

    issue(3'd0, 32'h8000_0000, 32'h8000_0000);
    wait_idle(n);
    check("mult_min_hi", HI, 32'h4000_0000);
    check("mult_min_lo", LO, 32'h0000_0000);

    issue(3'd2, 32'hFFFF_FFF9, 32'd2);
    wait_idle(n);
    check("div_lat", n, 32'd10);
    check("div_lo", LO, 32'hFFFF_FFFD);
    check("div_hi", HI, 32'hFFFF_FFFF);

    issue(3'd3, 32'd7, 32'd2);
    wait_idle(n);
    check("divu_lat", n, 32'd10);
    check("divu_lo", LO, 32'd3);
    check("divu_hi", HI, 32'd1);

    issue(3'd2, 32'h8000_0000, 32'hFFFF_FFFF);
    wait_idle(n);
    check("div_ovf_lo", LO, 32'h8000_0000);
    check("div_ovf_hi", HI, 32'h0);

    issue(3'd4, 32'h11, 32'd0);
    check("mthi_busy", {31'd0, busy}, 32'h0);
    check("mthi_hi", HI, 32'h11);
    check("mthi_lo", LO, 32'h8000_0000);
    issue(3'd5, 32'h22, 32'd0);
    check("mtlo_lo", LO, 32'h22);
    check("mtlo_hi", HI, 32'h11);

    issue(3'd2, 32'd5, 32'd0);
    wait_idle(n);
    check("dbz_lat", n, 32'd10);
    check("dbz_hi", HI, 32'h11);
    check("dbz_lo", LO, 32'h22);

    // MULT 3*4 with two extra starts presented while it runs
    @(negedge clk);
    start = 1'b1; op = 3'd0; A = 32'd3; B = 32'd4;
    @(negedge clk);
    op = 3'd5; A = 32'hDEAD; B = 32'd0;
    @(negedge clk);
    op = 3'd3; A = 32'd7; B = 32'd2;
    @(negedge clk);
    start = 1'b0;
    check("ign_lo_mid", LO, 32'h22);
    wait_idle(n);
    check("ign_lat", n + 2, 32'd5);
    check("ign_lo", LO, 32'd12);
    check("ign_hi", HI, 32'd0);
    repeat (12) @(negedge clk);
    check("ign_busy_late", {31'd0, busy}, 32'h0);
    check("ign_lo_late", LO, 32'd12);

    issue(3'd4, 32'h0, 32'd0);
    issue(3'd5, 32'hFFFF_FFFF, 32'd0);
    issue(3'd7, 32'd1, 32'd1);
`ifdef MDU_MADD_EN
    wait_idle(n);
    check("maddu_lat", n, 32'd5);
    check("maddu_hi", HI, 32'h1);
    check("maddu_lo", LO, 32'h0);
`else
    check("maddu_nobusy", {31'd0, busy}, 32'h0);
    repeat (6) @(negedge clk);
    check("maddu_hi", HI, 32'h0);
    check("maddu_lo", LO, 32'hFFFF_FFFF);
`endif

    issue(3'd4, 32'h55, 32'd0);
    issue(3'd5, 32'h66, 32'd0);
    issue(3'd2, 32'd100, 32'd7);
    repeat (6) @(negedge clk);
    check("rstmid_busy_pre", {31'd0, busy}, 32'h1);
    reset = 1'b0;
    #1;
    check("rstmid_hi", HI, 32'h0);
    check("rstmid_lo", LO, 32'h0);
    check("rstmid_busy", {31'd0, busy}, 32'h0);
    @(negedge clk);
    reset = 1'b1;
    repeat (20) @(negedge clk);
    check("rstmid_hi_late", HI, 32'h0);
    check("rstmid_lo_late", LO, 32'h0);
    check("rstmid_busy_late", {31'd0, busy}, 32'h0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
